// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// send-sequencer state type.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with an occupancy count, a sticky overflow flag and
// a synchronous flush.
module sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              flush,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // full comes from the registered count, so a push while full is dropped
    // even when a pop frees a slot on the same edge.
    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        push_ok = wr_en && !full && !flush;
        pop_ok  = pop && !empty && !flush;
        rd_data = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx: queues bytes and launches them one at a
// time, pacing on uart_tx's ready handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = uart_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [DATA_W-1:0] tx_data,
    output logic              send_trigger,
    input  logic              tx_ready
);

    tx_state_t         state;
    logic              launch;
    logic [DATA_W-1:0] head_data;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .flush    (flush),
        .pop      (launch),
        .rd_data  (head_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        launch = (state == IDLE) && !empty && tx_ready && !flush;
    end

    // flush never aborts a byte already handed to uart_tx; it only blocks
    // a launch in the cycle it is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tx_data      <= '0;
            send_trigger <= 1'b0;
        end else begin
            send_trigger <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        tx_data      <= head_data;
                        send_trigger <= 1'b1;
                        state        <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!tx_ready)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
